// File: rtl/perf_pkg.sv
// perf_pkg: shared definitions for the performance snapshot collector.
//   perf_col_state_e : collector FSM state encoding
//   PERF_*_DEF       : default parameter values for the collector
package perf_pkg;

    localparam int unsigned PERF_NUM_CNTR_DEF = 4;
    localparam int unsigned PERF_CNT_W_DEF    = 4;
    localparam int unsigned PERF_ACC_W_DEF    = 16;

    typedef enum logic [1:0] {
        PC_IDLE    = 2'd0,
        PC_SAMPLE  = 2'd1,
        PC_PRESENT = 2'd2
    } perf_col_state_e;

endpackage

// File: rtl/perf_sat_acc.sv
// perf_sat_acc: saturating accumulate adder.
//   acc_i [ACC_W] : current accumulator value
//   add_i [CNT_W] : increment
//   sum_o [ACC_W] : acc_i + add_i, clamped to all-ones on overflow
//   ovf_o         : high when the true sum does not fit in ACC_W bits
module perf_sat_acc #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [CNT_W-1:0] add_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [ACC_W:0] raw_sum;

    always_comb begin
        raw_sum = {1'b0, acc_i} + {{(ACC_W + 1 - CNT_W){1'b0}}, add_i};
        ovf_o   = raw_sum[ACC_W];
        sum_o   = ovf_o ? '1 : raw_sum[ACC_W-1:0];
    end

endmodule

// File: rtl/perf_snapshot_collector.sv
// perf_snapshot_collector: on a snapshot request, reads each upstream
// counter once (read-and-clear strobe), adds the value into a per-counter
// saturating accumulator and presents each total as a valid/ready beat.
//   clk, reset        : clock, synchronous active-high reset
//   snap_req_i        : start a sweep (queued one-deep while busy)
//   acc_clr_i         : clear accumulators/sat flags in IDLE
//                       (present only with PERF_COLLECT_CLR_EN defined)
//   sw_req_o  [N]     : one-hot read strobe to counter idx
//   p_count_i [N*W]   : counter values, slice i valid when sw_req_o[i]
//   rd_valid_o/rd_ready_i/rd_id_o/rd_data_o : result beat handshake
//   sat_o     [N]     : sticky saturation flags
//   busy_o            : sweep in progress
// Optional feature macro: PERF_COLLECT_CLR_EN.
module perf_snapshot_collector
    import perf_pkg::*;
#(
    parameter int unsigned NUM_CNTR = PERF_NUM_CNTR_DEF,
    parameter int unsigned CNT_W    = PERF_CNT_W_DEF,
    parameter int unsigned ACC_W    = PERF_ACC_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          snap_req_i,
`ifdef PERF_COLLECT_CLR_EN
    input  logic                          acc_clr_i,
`endif
    output logic [NUM_CNTR-1:0]           sw_req_o,
    input  logic [NUM_CNTR*CNT_W-1:0]     p_count_i,
    output logic                          rd_valid_o,
    input  logic                          rd_ready_i,
    output logic [$clog2(NUM_CNTR)-1:0]   rd_id_o,
    output logic [ACC_W-1:0]              rd_data_o,
    output logic [NUM_CNTR-1:0]           sat_o,
    output logic                          busy_o
);

    localparam int unsigned IDX_W = $clog2(NUM_CNTR);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CNTR - 1);

    perf_col_state_e    state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pending_q, pending_d;
    logic [ACC_W-1:0]   acc_q [NUM_CNTR];
    logic [NUM_CNTR-1:0] sat_q;

    logic [ACC_W-1:0]   acc_sel;
    logic [CNT_W-1:0]   cnt_sel;
    logic [ACC_W-1:0]   acc_sum;
    logic               acc_ovf;
    logic               clr_en;

`ifdef PERF_COLLECT_CLR_EN
    // Clear only honoured while idle; a concurrent snapshot then samples
    // into freshly zeroed accumulators.
    assign clr_en = acc_clr_i && (state_q == PC_IDLE);
`else
    assign clr_en = 1'b0;
`endif

    // Single adder shared by all counters through the idx mux.
    assign acc_sel = acc_q[idx_q];
    assign cnt_sel = p_count_i[idx_q*CNT_W +: CNT_W];

    perf_sat_acc #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_sat_acc (
        .acc_i (acc_sel),
        .add_i (cnt_sel),
        .sum_o (acc_sum),
        .ovf_o (acc_ovf)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        sw_req_o   = '0;
        rd_valid_o = 1'b0;
        rd_id_o    = '0;
        rd_data_o  = '0;
        busy_o     = (state_q != PC_IDLE);

        case (state_q)
            PC_IDLE: begin
                if (snap_req_i || pending_q) begin
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = PC_SAMPLE;
                end
            end
            PC_SAMPLE: begin
                sw_req_o = NUM_CNTR'(1) << idx_q;
                state_d  = PC_PRESENT;
                if (snap_req_i) pending_d = 1'b1;
            end
            PC_PRESENT: begin
                rd_valid_o = 1'b1;
                rd_id_o    = idx_q;
                rd_data_o  = acc_sel;
                if (snap_req_i) pending_d = 1'b1;
                if (rd_ready_i) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = PC_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = PC_SAMPLE;
                    end
                end
            end
            default: state_d = PC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PC_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_en) begin
            for (int unsigned i = 0; i < NUM_CNTR; i++) acc_q[i] <= '0;
            sat_q <= '0;
        end else if (state_q == PC_SAMPLE) begin
            acc_q[idx_q] <= acc_sum;
            if (acc_ovf) sat_q[idx_q] <= 1'b1;
        end
    end

    assign sat_o = sat_q;

endmodule

// File: tb/tb_perf_snapshot_collector.sv
// tb_perf_snapshot_collector: self-checking bench for
// perf_snapshot_collector. Two instances share stimulus: a default-width
// one (ACC_W=16) and a narrow one (ACC_W=5) that exercises saturation.
module tb_perf_snapshot_collector;

    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int AW  = 16;
    localparam int AWS = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            snap;
    logic            ready;
    logic            acc_clr;
    logic [N*CW-1:0] pc;

    logic [N-1:0]    sw, sw_s, sat, sat_s;
    logic            v, v_s, busy, busy_s;
    logic [1:0]      id, id_s;
    logic [AW-1:0]   rd;
    logic [AWS-1:0]  rd_s;

    int checks = 0;
    int errors = 0;

    int unsigned m_acc   [N];
    int unsigned m_acc_s [N];
    bit [N-1:0]  m_sat, m_sat_s;

    always #5 clk = ~clk;

    perf_snapshot_collector #(.NUM_CNTR(N), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .snap_req_i (snap),
`ifdef PERF_COLLECT_CLR_EN
        .acc_clr_i  (acc_clr),
`endif
        .sw_req_o   (sw),
        .p_count_i  (pc),
        .rd_valid_o (v),
        .rd_ready_i (ready),
        .rd_id_o    (id),
        .rd_data_o  (rd),
        .sat_o      (sat),
        .busy_o     (busy)
    );

    perf_snapshot_collector #(.NUM_CNTR(N), .CNT_W(CW), .ACC_W(AWS)) dut_s (
        .clk        (clk),
        .reset      (reset),
        .snap_req_i (snap),
`ifdef PERF_COLLECT_CLR_EN
        .acc_clr_i  (acc_clr),
`endif
        .sw_req_o   (sw_s),
        .p_count_i  (pc),
        .rd_valid_o (v_s),
        .rd_ready_i (ready),
        .rd_id_o    (id_s),
        .rd_data_o  (rd_s),
        .sat_o      (sat_s),
        .busy_o     (busy_s)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_acc[i]   = 0;
            m_acc_s[i] = 0;
        end
        m_sat   = '0;
        m_sat_s = '0;
    endtask

    task automatic model_add(input int i, input int unsigned val);
        m_acc[i]   = m_acc[i] + val;
        m_acc_s[i] = m_acc_s[i] + val;
        if (m_acc[i] > (2**AW - 1)) begin
            m_acc[i] = 2**AW - 1;
            m_sat[i] = 1'b1;
        end
        if (m_acc_s[i] > (2**AWS - 1)) begin
            m_acc_s[i] = 2**AWS - 1;
            m_sat_s[i] = 1'b1;
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_sw"},    {sw_s, sw}, 0);
        check_val({tag, "_valid"}, {v_s, v}, 0);
        check_val({tag, "_busy"},  {busy_s, busy}, 0);
    endtask

    task automatic check_present(input string tag, input int i);
        check_val({tag, "_valid"}, v, 1);
        check_val({tag, "_id"},    id, i);
        check_val({tag, "_data"},  rd, m_acc[i]);
        check_val({tag, "_data5"}, rd_s, m_acc_s[i]);
        check_val({tag, "_sw"},    sw, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    // stall_idx: -1 no stalls, -2 random stalls, else stall stall_len at that beat
    task automatic run_sweep(input bit do_snap, input bit extra, input int stall_idx,
                             input int stall_len, input bit fixed, input logic [15:0] fpc,
                             input bit clr_start, input bit clr_busy);
        logic [15:0] cur;
        int stall;
        snap    = do_snap;
        acc_clr = clr_start;
        if (clr_start) model_clear();
        tick();
        snap    = 1'b0;
        acc_clr = clr_busy;
        for (int i = 0; i < N; i++) begin
            cur = fixed ? fpc : 16'($urandom);
            pc  = cur;
            if (extra && (i == 1 || i == 2)) snap = 1'b1;
            check_val("sample_sw", sw, 1 << i);
            check_val("sample_busy", busy, 1);
            check_val("sample_valid", v, 0);
            tick();
            snap = 1'b0;
            model_add(i, (cur >> (i * CW)) & 4'hF);
            pc = 16'($urandom);
            if (stall_idx == -2)     stall = $urandom_range(0, 2);
            else if (stall_idx == i) stall = stall_len;
            else                     stall = 0;
            check_present("present", i);
            ready = 1'b0;
            for (int k = 0; k < stall; k++) begin
                tick();
                check_present("stall", i);
            end
            ready = 1'b1;
            tick();
        end
        acc_clr = 1'b0;
        check_idle("end");
        check_val("sat16", sat, m_sat);
        check_val("sat5", sat_s, m_sat_s);
    endtask

    task automatic abort_sweep();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc = 16'($urandom);
            tick();
            if (i < 2) tick();
        end
        check_val("abort_pre_valid", v, 1);
        check_val("abort_pre_id", id, 2);
        reset = 1'b1;
        tick();
        check_idle("abort");
        check_val("abort_id", id, 0);
        check_val("abort_data", {rd_s, rd}, 0);
        reset = 1'b0;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle("post_abort");
        end
    endtask

    initial begin
        reset   = 1'b1;
        snap    = 1'b0;
        ready   = 1'b1;
        acc_clr = 1'b0;
        pc      = '0;
        tick();
        tick();
        check_idle("reset");
        check_val("reset_id", id, 0);
        check_val("reset_data", {rd_s, rd}, 0);
        check_val("reset_sat", {sat_s, sat}, 0);
        reset = 1'b0;
        model_clear();
        tick();

        // Fixed pattern {3,1,0,2}, twice, then with a 5-cycle stall at idx 1
        run_sweep(1, 0, -1, 0, 1, 16'h2013, 0, 0);
        run_sweep(1, 0, -1, 0, 1, 16'h2013, 0, 0);
        check_val("sweep2_acc0", m_acc[0], 6);
        run_sweep(1, 0, 1, 5, 1, 16'h2013, 0, 0);

        // Saturation on the narrow instance: 15, 30, 31, 31
        pulse_reset();
        for (int s = 0; s < 4; s++) run_sweep(1, 0, -1, 0, 1, 16'h000F, 0, 0);
        check_val("sat5_bit0", sat_s[0], 1);

        // Two requests mid-sweep queue exactly one extra sweep
        run_sweep(1, 1, -2, 0, 0, 16'h0, 0, 0);
        run_sweep(0, 0, -2, 0, 0, 16'h0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_idle("no_third");
        end

        abort_sweep();

        for (int s = 0; s < 25; s++) begin
            run_sweep(1, 0, -2, 0, 0, 16'h0, 0, 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

`ifdef PERF_COLLECT_CLR_EN
        run_sweep(1, 0, -1, 0, 0, 16'h0, 1, 0);
        run_sweep(1, 0, -2, 0, 0, 16'h0, 0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
